// File: rtl/reg_alu_seq_pkg.sv
// Shared definitions for the reg_alu instruction sequencer.
// Holds the instruction width, the instruction-kind codes and the bit positions
// of every field inside a 16-bit instruction word.
package reg_alu_seq_pkg;

    localparam int unsigned InstrWidth = 16;

    // Field bit positions inside an instruction word
    localparam int unsigned KindHi = 15;
    localparam int unsigned KindLo = 14;
    localparam int unsigned OpHi   = 13;
    localparam int unsigned OpLo   = 12;
    localparam int unsigned WaHi   = 11;
    localparam int unsigned WaLo   = 9;
    localparam int unsigned RaHi   = 8;
    localparam int unsigned RaLo   = 6;
    localparam int unsigned RbHi   = 5;
    localparam int unsigned RbLo   = 3;
    localparam int unsigned ImmHi  = 7;
    localparam int unsigned ImmLo  = 0;

    typedef enum logic [1:0] {
        KindNop = 2'b00,
        KindLdi = 2'b01,
        KindAlu = 2'b10,
        KindRd  = 2'b11
    } kind_e;

    function automatic kind_e instr_kind(input logic [InstrWidth-1:0] instr);
        return kind_e'(instr[KindHi:KindLo]);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO for reg_alu_seq.
// Ports:
//   clk_i   - rising-edge clock
//   rst_i   - asynchronous active-high reset (clears pointers and count)
//   push_i  - write data_i; accepted when not full or when popping in the same cycle
//   data_i  - entry to write
//   pop_i   - remove the head entry (ignored when empty)
//   data_o  - head entry
//   empty_o - no entries held
//   full_o  - DEPTH entries held
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A simultaneous pop frees the slot, so a push while full is still taken
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/reg_alu_seq.sv
// Instruction sequencer driving an external reg_alu (register file + ALU).
// Instructions are queued in a FIFO, moved into a single issue register and
// decoded from there, one cycle per instruction. RD results are captured into a
// valid/ready result register; an RD that cannot deliver stalls the pipeline.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   in_valid/in_instr/in_ready - instruction input handshake
//   sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in - reg_alu controls
//   d_out_a                 - reg_alu read port A (combinational from rd_addr_a)
//   res_valid/res_data/res_ready - captured read result handshake
//   busy                    - FIFO non-empty or an instruction is issuing
module reg_alu_seq
    import reg_alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [InstrWidth-1:0] in_instr,
    output logic                  in_ready,
    output logic                  sel,
    output logic                  wr,
    output logic [1:0]            op,
    output logic [2:0]            rd_addr_a,
    output logic [2:0]            rd_addr_b,
    output logic [2:0]            wr_addr,
    output logic [7:0]            d_in,
    input  logic [7:0]            d_out_a,
    output logic                  res_valid,
    output logic [7:0]            res_data,
    input  logic                  res_ready,
    output logic                  busy
);

    logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [InstrWidth-1:0] fifo_head;

    logic                  iss_valid_q;
    logic [InstrWidth-1:0] iss_instr_q;
    logic                  res_valid_q;
    logic [7:0]            res_data_q;

    kind_e                 iss_kind;
    logic                  rd_blocked, retire, rd_retire, load;

    instr_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(InstrWidth)
    ) u_fifo (
        .clk_i  (clk),
        .rst_i  (reset),
        .push_i (fifo_push),
        .data_i (in_instr),
        .pop_i  (fifo_pop),
        .data_o (fifo_head),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    assign in_ready  = !reset && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    assign iss_kind   = instr_kind(iss_instr_q);
    // An RD may only retire if the previous result is gone or leaving now
    assign rd_blocked = (iss_kind == KindRd) && res_valid_q && !res_ready;
    assign retire     = iss_valid_q && !rd_blocked;
    assign rd_retire  = retire && (iss_kind == KindRd);
    assign load       = !fifo_empty && (!iss_valid_q || retire);
    assign fifo_pop   = load;

    assign busy      = !fifo_empty || iss_valid_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid_q <= 1'b0;
            iss_instr_q <= '0;
        end else if (load) begin
            iss_valid_q <= 1'b1;
            iss_instr_q <= fifo_head;
        end else if (retire) begin
            iss_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else if (rd_retire) begin
            res_valid_q <= 1'b1;
            res_data_q  <= d_out_a;
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    // Controls come only from the issue register; an empty slot gives idle values
    always_comb begin
        sel       = 1'b0;
        wr        = 1'b0;
        op        = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_addr   = '0;
        d_in      = '0;
        if (iss_valid_q) begin
            unique case (iss_kind)
                KindLdi: begin
                    wr      = 1'b1;
                    wr_addr = iss_instr_q[WaHi:WaLo];
                    d_in    = iss_instr_q[ImmHi:ImmLo];
                end
                KindAlu: begin
                    wr        = 1'b1;
                    sel       = 1'b1;
                    op        = iss_instr_q[OpHi:OpLo];
                    wr_addr   = iss_instr_q[WaHi:WaLo];
                    rd_addr_a = iss_instr_q[RaHi:RaLo];
                    rd_addr_b = iss_instr_q[RbHi:RbLo];
                end
                KindRd: begin
                    rd_addr_a = iss_instr_q[RaHi:RaLo];
                end
                KindNop: begin
                end
            endcase
        end
    end

endmodule
